// File: rtl/action_engine_mc_pkg.sv
// Shared definitions for the parametrised RMT action engine: opcodes,
// sub-action field layout and container widths.
package action_engine_mc_pkg;

  localparam int unsigned W6 = 48;
  localparam int unsigned W4 = 32;
  localparam int unsigned W2 = 16;

  localparam int unsigned SUB_W    = 25;
  localparam int unsigned OP_LSB   = 21;
  localparam int unsigned OP_W     = 4;
  localparam int unsigned SRC1_LSB = 16;
  localparam int unsigned SRC2_LSB = 11;
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned IMM_LSB  = 0;
  localparam int unsigned IMM_W    = 16;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_SET  = 4'd3,
    OP_COPY = 4'd4,
    OP_ADDI = 4'd5
  } op_e;

  localparam logic [OP_W-1:0] META_DISCARD = 4'hF;
  localparam logic [OP_W-1:0] META_KEEP    = 4'hE;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [IDX_W-1:0] src1;
    logic [IDX_W-1:0] src2;
    logic [IMM_W-1:0] imm;
  } sub_act_t;

  // imm overlaps src2; both views are extracted from the same bits.
  function automatic sub_act_t decode_sub(input logic [SUB_W-1:0] s);
    sub_act_t d;
    d.op   = s[OP_LSB +: OP_W];
    d.src1 = s[SRC1_LSB +: IDX_W];
    d.src2 = s[SRC2_LSB +: IDX_W];
    d.imm  = s[IMM_LSB +: IMM_W];
    return d;
  endfunction

endpackage

// File: rtl/action_engine_mc_if.sv
// PHV/action input join and PHV output stream of one action engine stage.
interface action_engine_mc_if
  import action_engine_mc_pkg::*;
#(
  parameter int unsigned N6       = 8,
  parameter int unsigned N4       = 8,
  parameter int unsigned N2       = 8,
  parameter int unsigned META_LEN = 356,
  parameter int unsigned ACT_LEN  = 25
);
  localparam int unsigned PHV_LEN = W6*N6 + W4*N4 + W2*N2 + META_LEN;
  localparam int unsigned ACTW    = ACT_LEN*(N6 + N4 + N2 + 1);

  logic [PHV_LEN-1:0] phv_in;
  logic               phv_valid_in;
  logic               phv_ready_out;
  logic [ACTW-1:0]    action_in;
  logic               action_valid_in;
  logic               action_ready_out;
  logic [PHV_LEN-1:0] phv_out;
  logic               phv_valid_out;
  logic               phv_ready_in;

  modport master (
    output phv_in, phv_valid_in, action_in, action_valid_in, phv_ready_in,
    input  phv_ready_out, action_ready_out, phv_out, phv_valid_out
  );

  modport slave (
    input  phv_in, phv_valid_in, action_in, action_valid_in, phv_ready_in,
    output phv_ready_out, action_ready_out, phv_out, phv_valid_out
  );

endinterface

// File: rtl/action_engine_mc_alu.sv
// Per-container ALU: decodes one sub-action opcode and computes the result
// modulo DATA_WIDTH.
module alu_mc
  import action_engine_mc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [OP_W-1:0]       op,
  input  logic [DATA_WIDTH-1:0] c,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [IMM_W-1:0]      imm,
  output logic [DATA_WIDTH-1:0] y
);
  logic [DATA_WIDTH-1:0] imm_x;

  always_comb begin
    imm_x = DATA_WIDTH'(imm);
    y     = c;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_SET:  y = imm_x;
      OP_COPY: y = a;
      OP_ADDI: y = a + imm_x;
      default: y = c;
    endcase
  end

endmodule

// File: rtl/action_engine_mc.sv
// Two-stage flow-controlled action engine: S1 joins PHV+action and selects
// operands, S2 holds ALU results; both stages advance on a free output slot.
module action_engine_mc
  import action_engine_mc_pkg::*;
#(
  parameter int unsigned STAGE_ID = 0,
  parameter int unsigned N6       = 8,
  parameter int unsigned N4       = 8,
  parameter int unsigned N2       = 8,
  parameter int unsigned META_LEN = 356,
  parameter int unsigned ACT_LEN  = 25
) (
  input  logic                clk,
  input  logic                rst_n,
  action_engine_mc_if.slave   bus,
  output logic [31:0]         pkt_cnt,
  output logic [31:0]         drop_cnt
);
  localparam int unsigned PHV_LEN = W6*N6 + W4*N4 + W2*N2 + META_LEN;
  localparam int unsigned OFF2    = META_LEN;
  localparam int unsigned OFF4    = OFF2 + W2*N2;
  localparam int unsigned OFF6    = OFF4 + W4*N4;
  localparam int unsigned AOFF2   = ACT_LEN;
  localparam int unsigned AOFF4   = AOFF2 + ACT_LEN*N2;
  localparam int unsigned AOFF6   = AOFF4 + ACT_LEN*N4;

  if (META_LEN < 8 || ACT_LEN < SUB_W) begin : g_bad_cfg
    $error("action_engine_mc stage %0d: META_LEN must be >= 8 and ACT_LEN >= 25", STAGE_ID);
  end

  logic advance, in_hs, out_hs;
  logic               s1_valid_d, s1_valid_q;
  logic [PHV_LEN-1:0] s1_phv_d, s1_phv_q;
  logic [OP_W-1:0]    meta_op_d, meta_op_q;
  logic               phv_valid_d, phv_valid_q;
  logic [PHV_LEN-1:0] phv_d, phv_q;
  logic [31:0]        pkt_d, pkt_q, drop_d, drop_q;
  logic               unused_meta_bits;

  logic [W6-1:0] c6_in [N6];
  logic [W4-1:0] c4_in [N4];
  logic [W2-1:0] c2_in [N2];
  logic [W6-1:0] res6 [N6];
  logic [W4-1:0] res4 [N4];
  logic [W2-1:0] res2 [N2];

  // Advance depends only on the output register, so the pipeline collapses
  // bubbles and releases a stall without an empty cycle.
  assign advance = ~phv_valid_q | bus.phv_ready_in;
  assign in_hs   = rst_n & advance & bus.phv_valid_in & bus.action_valid_in;
  assign out_hs  = phv_valid_q & bus.phv_ready_in;

  assign bus.phv_ready_out    = in_hs;
  assign bus.action_ready_out = in_hs;
  assign bus.phv_out          = phv_q;
  assign bus.phv_valid_out    = phv_valid_q;
  assign pkt_cnt              = pkt_q;
  assign drop_cnt             = drop_q;
  assign unused_meta_bits     = ^bus.action_in[OP_LSB-1:0];

  for (genvar i = 0; i < N6; i++) begin : g_c6
    sub_act_t        sub;
    logic [W6-1:0]   a_d, a_q, b_d, b_q;
    logic [OP_W-1:0] op_d, op_q;
    logic [IMM_W-1:0] imm_d, imm_q;
    assign c6_in[i] = bus.phv_in[OFF6 + W6*i +: W6];
    assign sub      = decode_sub(bus.action_in[AOFF6 + ACT_LEN*i +: SUB_W]);
    always_comb begin
      a_d = a_q; b_d = b_q; op_d = op_q; imm_d = imm_q;
      if (advance) begin
        a_d = '0; b_d = '0; op_d = sub.op; imm_d = sub.imm;
        for (int unsigned k = 0; k < N6; k++) begin
          if (32'(sub.src1) == k) a_d = c6_in[k];
          if (32'(sub.src2) == k) b_d = c6_in[k];
        end
      end
    end
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        a_q <= '0; b_q <= '0; op_q <= '0; imm_q <= '0;
      end else begin
        a_q <= a_d; b_q <= b_d; op_q <= op_d; imm_q <= imm_d;
      end
    end
    alu_mc #(.DATA_WIDTH(W6)) u_alu (
      .op(op_q), .c(s1_phv_q[OFF6 + W6*i +: W6]), .a(a_q), .b(b_q), .imm(imm_q), .y(res6[i])
    );
  end

  for (genvar i = 0; i < N4; i++) begin : g_c4
    sub_act_t        sub;
    logic [W4-1:0]   a_d, a_q, b_d, b_q;
    logic [OP_W-1:0] op_d, op_q;
    logic [IMM_W-1:0] imm_d, imm_q;
    assign c4_in[i] = bus.phv_in[OFF4 + W4*i +: W4];
    assign sub      = decode_sub(bus.action_in[AOFF4 + ACT_LEN*i +: SUB_W]);
    always_comb begin
      a_d = a_q; b_d = b_q; op_d = op_q; imm_d = imm_q;
      if (advance) begin
        a_d = '0; b_d = '0; op_d = sub.op; imm_d = sub.imm;
        for (int unsigned k = 0; k < N4; k++) begin
          if (32'(sub.src1) == k) a_d = c4_in[k];
          if (32'(sub.src2) == k) b_d = c4_in[k];
        end
      end
    end
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        a_q <= '0; b_q <= '0; op_q <= '0; imm_q <= '0;
      end else begin
        a_q <= a_d; b_q <= b_d; op_q <= op_d; imm_q <= imm_d;
      end
    end
    alu_mc #(.DATA_WIDTH(W4)) u_alu (
      .op(op_q), .c(s1_phv_q[OFF4 + W4*i +: W4]), .a(a_q), .b(b_q), .imm(imm_q), .y(res4[i])
    );
  end

  for (genvar i = 0; i < N2; i++) begin : g_c2
    sub_act_t        sub;
    logic [W2-1:0]   a_d, a_q, b_d, b_q;
    logic [OP_W-1:0] op_d, op_q;
    logic [IMM_W-1:0] imm_d, imm_q;
    assign c2_in[i] = bus.phv_in[OFF2 + W2*i +: W2];
    assign sub      = decode_sub(bus.action_in[AOFF2 + ACT_LEN*i +: SUB_W]);
    always_comb begin
      a_d = a_q; b_d = b_q; op_d = op_q; imm_d = imm_q;
      if (advance) begin
        a_d = '0; b_d = '0; op_d = sub.op; imm_d = sub.imm;
        for (int unsigned k = 0; k < N2; k++) begin
          if (32'(sub.src1) == k) a_d = c2_in[k];
          if (32'(sub.src2) == k) b_d = c2_in[k];
        end
      end
    end
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        a_q <= '0; b_q <= '0; op_q <= '0; imm_q <= '0;
      end else begin
        a_q <= a_d; b_q <= b_d; op_q <= op_d; imm_q <= imm_d;
      end
    end
    alu_mc #(.DATA_WIDTH(W2)) u_alu (
      .op(op_q), .c(s1_phv_q[OFF2 + W2*i +: W2]), .a(a_q), .b(b_q), .imm(imm_q), .y(res2[i])
    );
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_phv_d    = s1_phv_q;
    meta_op_d   = meta_op_q;
    phv_valid_d = phv_valid_q;
    phv_d       = phv_q;
    if (advance) begin
      s1_valid_d  = in_hs;
      s1_phv_d    = bus.phv_in;
      meta_op_d   = bus.action_in[OP_LSB +: OP_W];
      phv_valid_d = s1_valid_q;
      phv_d       = s1_phv_q;
      for (int unsigned k = 0; k < N6; k++) phv_d[OFF6 + W6*k +: W6] = res6[k];
      for (int unsigned k = 0; k < N4; k++) phv_d[OFF4 + W4*k +: W4] = res4[k];
      for (int unsigned k = 0; k < N2; k++) phv_d[OFF2 + W2*k +: W2] = res2[k];
      if (meta_op_q == META_DISCARD)   phv_d[0] = 1'b1;
      else if (meta_op_q == META_KEEP) phv_d[0] = 1'b0;
    end
    pkt_d  = pkt_q + 32'(out_hs);
    drop_d = drop_q + 32'(out_hs & phv_q[0]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_phv_q    <= '0;
      meta_op_q   <= '0;
      phv_valid_q <= 1'b0;
      phv_q       <= '0;
      pkt_q       <= '0;
      drop_q      <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_phv_q    <= s1_phv_d;
      meta_op_q   <= meta_op_d;
      phv_valid_q <= phv_valid_d;
      phv_q       <= phv_d;
      pkt_q       <= pkt_d;
      drop_q      <= drop_d;
    end
  end

endmodule

// File: tb/tb_action_engine_mc.sv
// Directed bench for action_engine_mc with a container-level reference model
// and a per-cycle output/counter monitor.
module tb_action_engine_mc;
  localparam int N6 = 8, N4 = 8, N2 = 8, META = 356, AL = 25;
  localparam int PL = 48*N6 + 32*N4 + 16*N2 + META;
  localparam int AW = AL*(N6 + N4 + N2 + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] pkt_cnt, drop_cnt;

  action_engine_mc_if #(.N6(N6), .N4(N4), .N2(N2), .META_LEN(META), .ACT_LEN(AL)) bus ();

  action_engine_mc #(.STAGE_ID(0), .N6(N6), .N4(N4), .N2(N2), .META_LEN(META), .ACT_LEN(AL)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  logic [PL-1:0] exp_q[$];
  logic [PL-1:0] last_out, held;
  int n_out = 0, n_stall = 0;
  int m_pkt = 0, m_drop = 0;
  bit stall_prev = 0, rst_prev = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic chk_phv(input string name, input logic [PL-1:0] got, input logic [PL-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      for (int k = 0; k < (PL + 63)/64; k++) begin
        if (64'(got >> (64*k)) !== 64'(exp >> (64*k))) begin
          $display("FAIL %s: bits[%0d+:64] got=%h expected=%h", name, 64*k,
                   64'(got >> (64*k)), 64'(exp >> (64*k)));
          break;
        end
      end
    end
  endtask

  // ---- container-level reference model ----
  function automatic int cw(input int c);
    return (c == 0) ? 48 : (c == 1) ? 32 : 16;
  endfunction
  function automatic int coff(input int c, input int i);
    return (c == 0) ? META + 16*N2 + 32*N4 + 48*i : (c == 1) ? META + 16*N2 + 32*i : META + 16*i;
  endfunction
  function automatic int aoff(input int c, input int i);
    return (c == 0) ? AL*(1 + N2 + N4 + i) : (c == 1) ? AL*(1 + N2 + i) : (c == 2) ? AL*(1 + i) : 0;
  endfunction
  function automatic logic [63:0] cmask(input int c);
    return (64'd1 << cw(c)) - 64'd1;
  endfunction
  function automatic logic [63:0] get_c(input logic [PL-1:0] p, input int c, input int i);
    return 64'(p >> coff(c, i)) & cmask(c);
  endfunction
  function automatic logic [PL-1:0] set_c(input logic [PL-1:0] p, input int c, input int i, input logic [63:0] v);
    logic [PL-1:0] m;
    m = PL'(cmask(c)) << coff(c, i);
    return (p & ~m) | (PL'(v & cmask(c)) << coff(c, i));
  endfunction
  function automatic logic [AW-1:0] put_sub(input logic [AW-1:0] a, input int c, input int i, input logic [24:0] s);
    logic [AW-1:0] m;
    logic [24:0] ones;
    ones = '1;
    m = AW'(ones) << aoff(c, i);
    return (a & ~m) | (AW'(s) << aoff(c, i));
  endfunction
  function automatic logic [24:0] mk(input logic [3:0] op, input logic [4:0] s1, input logic [4:0] s2);
    return {op, s1, s2, 11'b0};
  endfunction
  function automatic logic [24:0] mki(input logic [3:0] op, input logic [4:0] s1, input logic [15:0] imm);
    return {op, s1, imm};
  endfunction

  function automatic logic [PL-1:0] model(input logic [PL-1:0] p, input logic [AW-1:0] a);
    logic [PL-1:0] r;
    logic [24:0] s;
    logic [63:0] av, bv, v, imm;
    r = p;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 8; i++) begin
        s   = 25'(a >> aoff(c, i));
        av  = (s[20:16] < 5'd8) ? get_c(p, c, int'(s[20:16])) : 64'd0;
        bv  = (s[15:11] < 5'd8) ? get_c(p, c, int'(s[15:11])) : 64'd0;
        imm = {48'd0, s[15:0]};
        case (s[24:21])
          4'd1:    v = av + bv;
          4'd2:    v = av - bv;
          4'd3:    v = imm;
          4'd4:    v = av;
          4'd5:    v = av + imm;
          default: v = get_c(p, c, i);
        endcase
        r = set_c(r, c, i, v);
      end
    end
    if (a[24:21] == 4'hF) r[0] = 1'b1;
    else if (a[24:21] == 4'hE) r[0] = 1'b0;
    return r;
  endfunction

  function automatic logic [PL-1:0] bg();
    logic [PL-1:0] r;
    r = '0;
    for (int i = 0; i < PL; i += 32) r = (r << 32) | PL'($urandom);
    return r;
  endfunction

  // ---- monitor: one compare process, sampled on the falling edge ----
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        m_pkt = 0; m_drop = 0; stall_prev = 0;
        if (rst_prev) begin
          chk("rst_valid_out", 64'(bus.phv_valid_out), 64'd0);
          chk("rst_ready", 64'({bus.phv_ready_out, bus.action_ready_out}), 64'd0);
          chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
          chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        end
        rst_prev = 1;
      end else begin
        rst_prev = 0;
        chk("pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        chk("join_ready_equal", 64'(bus.phv_ready_out), 64'(bus.action_ready_out));
        if (bus.phv_ready_out)
          chk("join_needs_both_valid", 64'(bus.phv_valid_in & bus.action_valid_in), 64'd1);
        if (bus.phv_valid_out && exp_q.size() == 0)
          chk("spurious_valid_out", 64'(bus.phv_valid_out), 64'd0);
        if (stall_prev) begin
          chk("stall_valid_held", 64'(bus.phv_valid_out), 64'd1);
          chk_phv("stall_phv_held", bus.phv_out, held);
        end
        if (bus.phv_valid_out && bus.phv_ready_in && exp_q.size() > 0) begin
          logic [PL-1:0] e;
          e = exp_q.pop_front();
          chk_phv("phv_out", bus.phv_out, e);
          last_out = bus.phv_out;
          n_out++;
          m_pkt++;
          if (e[0]) m_drop++;
        end
        stall_prev = bus.phv_valid_out & ~bus.phv_ready_in;
        if (stall_prev) n_stall++;
        held = bus.phv_out;
        if (bus.phv_ready_out) exp_q.push_back(model(bus.phv_in, bus.action_in));
      end
    end
  end

  // ---- stimulus helpers (drive at posedge+1) ----
  task automatic xfer(input logic [PL-1:0] p, input logic [AW-1:0] a);
    int t;
    bus.phv_in = p; bus.action_in = a;
    bus.phv_valid_in = 1'b1; bus.action_valid_in = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.phv_ready_out && t < 100);
    chk("xfer_accepted", 64'(bus.phv_ready_out), 64'd1);
    @(posedge clk); #1;
    bus.phv_valid_in = 1'b0; bus.action_valid_in = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.phv_valid_in = 1'b0; bus.action_valid_in = 1'b0; bus.phv_ready_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(exp_q.size() == 0 && !bus.phv_valid_out) && t < 60);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [PL-1:0] p, e;
    logic [AW-1:0] a;
    logic [PL-1:0] sp[10];
    logic [AW-1:0] sa[10];
    int base_out, base_stall;

    bus.phv_in = '0; bus.action_in = '0;
    bus.phv_valid_in = 1'b1; bus.action_valid_in = 1'b1; bus.phv_ready_in = 1'b1;
    // reset state, with both inputs offering data
    @(posedge clk); @(negedge clk);
    chk("reset_ready_gated", 64'(bus.phv_ready_out), 64'd0);
    @(posedge clk); #1;
    chk("reset_valid_out", 64'(bus.phv_valid_out), 64'd0);
    chk("reset_phv_out", 64'(bus.phv_out), 64'd0);
    chk("reset_pkt_cnt", 64'(pkt_cnt), 64'd0);
    do_reset();

    // ADD wrap in 4B
    p = bg();
    p = set_c(p, 1, 2, 64'hFFFF_FFFF);
    p = set_c(p, 1, 3, 64'h1);
    a = '0;
    a = put_sub(a, 1, 0, mk(4'd1, 5'd2, 5'd3));
    xfer(p, a);
    drain();
    chk("add_wrap_4b0", get_c(last_out, 1, 0), 64'h0);
    chk_phv("add_others_unchanged", last_out, set_c(p, 1, 0, 64'h0));

    // SET 6B and 2B
    p = bg(); a = '0;
    a = put_sub(a, 0, 5, mki(4'd3, 5'd0, 16'hABCD));
    a = put_sub(a, 2, 7, mki(4'd3, 5'd0, 16'hABCD));
    xfer(p, a);
    drain();
    chk("set_6b5", get_c(last_out, 0, 5), 64'h0000_0000_ABCD);
    chk("set_2b7", get_c(last_out, 2, 7), 64'hABCD);

    // out-of-range and boundary indices, SUB/ADDI wrap, undefined op
    p = bg();
    p = set_c(p, 0, 7, 64'h1234_5678_9ABC);
    p = set_c(p, 0, 2, 64'hFFFF_FFFF_FFFF);
    p = set_c(p, 2, 2, 64'h1);
    p = set_c(p, 2, 3, 64'h2);
    p = set_c(p, 2, 5, 64'hFFF0);
    p = set_c(p, 1, 5, 64'hCAFE_F00D);
    a = '0;
    a = put_sub(a, 2, 1, mk(4'd4, 5'd20, 5'd0));
    a = put_sub(a, 1, 4, mk(4'd4, 5'd8, 5'd0));
    a = put_sub(a, 0, 0, mk(4'd4, 5'd7, 5'd0));
    a = put_sub(a, 2, 0, mk(4'd2, 5'd2, 5'd3));
    a = put_sub(a, 0, 1, mki(4'd5, 5'd2, 16'h0001));
    a = put_sub(a, 2, 4, mki(4'd5, 5'd5, 16'h0020));
    a = put_sub(a, 1, 5, mk(4'd7, 5'd0, 5'd1));
    xfer(p, a);
    drain();
    chk("copy_idx20_2b", get_c(last_out, 2, 1), 64'h0);
    chk("copy_idx8_4b", get_c(last_out, 1, 4), 64'h0);
    chk("copy_idx7_6b", get_c(last_out, 0, 0), 64'h1234_5678_9ABC);
    chk("sub_wrap_2b", get_c(last_out, 2, 0), 64'hFFFF);
    chk("addi_wrap_6b", get_c(last_out, 0, 1), 64'h0);
    chk("addi_wrap_2b", get_c(last_out, 2, 4), 64'h0010);
    chk("undef_op_nop", get_c(last_out, 1, 5), 64'hCAFE_F00D);

    // meta discard / keep / other
    do_reset();
    p = bg(); p[0] = 1'b0; a = '0; a[24:21] = 4'hF;
    xfer(p, a);
    drain();
    chk("meta_discard_bit", 64'(last_out[0]), 64'd1);
    chk("meta_drop_cnt", 64'(drop_cnt), 64'd1);
    chk("meta_pkt_cnt", 64'(pkt_cnt), 64'd1);
    p = bg(); p[0] = 1'b1; a = '0; a[24:21] = 4'hE;
    xfer(p, a);
    drain();
    chk("meta_keep_bit", 64'(last_out[0]), 64'd0);
    chk_phv("meta_keep_rest", last_out, {p[PL-1:1], 1'b0});
    p = bg(); p[0] = 1'b1; a = '0; a[24:21] = 4'h3;
    xfer(p, a);
    drain();
    chk("meta_other_bit", 64'(last_out[0]), 64'd1);
    chk("meta_drop_cnt2", 64'(drop_cnt), 64'd2);

    // join and latency: PHV at cycle 0, action at cycle 3, output at cycle 5
    do_reset();
    base_out = n_out;
    bus.phv_in = bg(); bus.action_in = '0;
    bus.phv_valid_in = 1'b1; bus.action_valid_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("join_wait_ready", 64'(bus.phv_ready_out), 64'd0);
      @(posedge clk); #1;
    end
    bus.action_valid_in = 1'b1;
    @(negedge clk);
    chk("join_ready_c3", 64'(bus.phv_ready_out), 64'd1);
    @(posedge clk); #1;
    bus.phv_valid_in = 1'b0; bus.action_valid_in = 1'b0;
    @(negedge clk);
    chk("lat_c4_valid", 64'(bus.phv_valid_out), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_c5_valid", 64'(bus.phv_valid_out), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_c6_valid", 64'(bus.phv_valid_out), 64'd0);
    @(posedge clk); #1;
    chk("lat_single_out", 64'(n_out - base_out), 64'd1);

    // stream of 10 with downstream stall in cycles 4..7
    do_reset();
    for (int k = 0; k < 10; k++) begin
      sp[k] = bg();
      sa[k] = '0;
      for (int c = 0; c < 3; c++)
        for (int i = 0; i < 8; i++)
          sa[k] = put_sub(sa[k], c, i, {4'($urandom_range(0, 7)), 5'($urandom_range(0, 9)), 16'($urandom)});
      sa[k] = put_sub(sa[k], 3, 0, {((k % 2) == 0) ? 4'hF : 4'h0, 21'($urandom)});
    end
    base_out = n_out; base_stall = n_stall;
    fork
      for (int k = 0; k < 10; k++) xfer(sp[k], sa[k]);
      begin
        repeat (4) @(posedge clk);
        #1 bus.phv_ready_in = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus.phv_ready_in = 1'b1;
      end
    join
    drain();
    chk("stream_pkt_cnt", 64'(pkt_cnt), 64'd10);
    chk("stream_outputs", 64'(n_out - base_out), 64'd10);
    chk("stream_stall_cycles", 64'(n_stall - base_stall), 64'd4);

    // reset with two PHVs in flight
    base_out = n_out;
    xfer(bg(), '0);
    xfer(bg(), '0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid_out", 64'(bus.phv_valid_out), 64'd0);
    chk("midrst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("midrst_drop_cnt", 64'(drop_cnt), 64'd0);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_output", 64'(n_out - base_out), 64'd0);
    chk("midrst_pkt_after", 64'(pkt_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
